// File: rtl/uart_com.sv
// 8N1 UART transceiver for the memory controller's serial port.
// TX serialises one byte per tx_start; RX deserialises into a small FIFO
// popped on each rising edge of rx_ack. Status and error flags are registered.
module uart_com #(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // ---------------------------------------------------------------- TX
  uart_st_e        tx_state;
  logic [CntW-1:0] tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_shift;

  // TX FSM: uart_txd and tx_ready are registered, updated with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= StIdle;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      unique case (tx_state)
        StIdle: begin
          if (tx_start) begin
            tx_shift <= tx_data;
            uart_txd <= 1'b0;
            tx_ready <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= StStart;
          end
        end
        StStart: begin
          if (tx_cnt == BitEnd) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_txd <= tx_shift[0];
            tx_state <= StData;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        StData: begin
          if (tx_cnt == BitEnd) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_txd <= 1'b1;
              tx_state <= StStop;
            end else begin
              // Shift so the next bit always sits at index 0 after this edge.
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_txd <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        StStop: begin
          if (tx_cnt == BitEnd) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= StIdle;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  uart_st_e        rx_state;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rxd_meta;
  logic            rxd_sync;
  logic            rx_push;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Valid stop bit sampled this cycle: hand the byte to the FIFO.
  assign rx_push = (rx_state == StStop) && (rx_cnt == BitEnd) && rxd_sync;

  // RX FSM: centre on the start bit, then sample every bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= StIdle;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      unique case (rx_state)
        StIdle: begin
          if (!rxd_sync) begin
            rx_cnt   <= '0;
            rx_state <= StStart;
          end
        end
        StStart: begin
          if (rx_cnt == HalfEnd) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rxd_sync ? StIdle : StData;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        StData: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= StStop;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        StStop: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt   <= '0;
            if (!rxd_sync) frame_err <= 1'b1;
            rx_state <= StIdle;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [PtrW:0] rd_ptr;
  logic [PtrW:0] wr_ptr;
  logic [7:0]    mem [RX_FIFO_DEPTH];
  logic          rx_ack_q;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign empty   = (rd_ptr == wr_ptr);
  assign full    = (rd_ptr[PtrW-1:0] == wr_ptr[PtrW-1:0]) && (rd_ptr[PtrW] != wr_ptr[PtrW]);
  assign pop     = rx_ack && !rx_ack_q && !empty;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign push_ok = rx_push && (!full || pop);

  // FIFO pointers, storage and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rx_ack_q   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_ack_q <= rx_ack;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) begin
        mem[wr_ptr[PtrW-1:0]] <= rx_shift;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (rx_push && full && !pop) rx_overrun <= 1'b1;
    end
  end

  // Head-of-FIFO view; depends only on registered state.
  assign rx_ready = !empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[PtrW-1:0]];

endmodule

// File: tb/tb_uart_com.sv
// Self-checking bench for uart_com with an RX byte scoreboard.
module tb_uart_com;

  localparam int unsigned Cpb   = 8;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ack;
  logic       uart_txd;
  logic       uart_rxd;
  logic       rx_overrun;
  logic       frame_err;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb [$];

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_com #(
    .CLKS_PER_BIT (Cpb),
    .RX_FIFO_DEPTH(Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_ack    (rx_ack),
    .uart_txd  (uart_txd),
    .uart_rxd  (uart_rxd),
    .rx_overrun(rx_overrun),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on the line, one negedge-aligned bit period per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (Cpb) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic wait_rx_ready(input int max_cyc);
    int k = 0;
    while (!rx_ready && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check("rx_ready_wait", 32'(rx_ready), 1);
  endtask

  // Compare the FIFO head with the scoreboard, then ack for hold cycles.
  task automatic read_byte(input int hold);
    logic [7:0] e;
    wait_rx_ready(200);
    e = (sb.size() > 0) ? sb.pop_front() : 8'hEE;
    check("rx_data", 32'(rx_data), 32'(e));
    rx_ack = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    int busy;
    int k;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    rx_ack   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(uart_txd), 1);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // TX of 0xA5 with an ignored tx_start mid-frame
    frame    = {1'b1, 8'hA5, 1'b0};
    busy     = 0;
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      if (j == 0) tx_start = 1'b0;
      if (!tx_ready) busy++;
      if (j % 8 == 0 || j % 8 == 4) check($sformatf("txd_bit%0d", j / 8), 32'(uart_txd),
                                            32'(frame[j/8]));
      if (j == 20) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
      end
      if (j == 21) tx_start = 1'b0;
    end
    @(negedge clk);
    check("tx_busy_cycles", busy, 80);
    check("tx_ready_after", 32'(tx_ready), 1);
    check("txd_idle_after", 32'(uart_txd), 1);

    // RX 0x3C, long ack gives a single pop
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    read_byte(5);
    check("rx_ready_after_3c", 32'(rx_ready), 0);
    check("rx_data_after_3c", 32'(rx_data), 0);

    // Short glitch is a false start
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_rx_ready", 32'(rx_ready), 0);
    check("glitch_frame_err", 32'(frame_err), 0);

    // Overrun: fifth byte dropped
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i <= 4) sb.push_back(8'(i));
    end
    check("overrun_set", 32'(rx_overrun), 1);
    read_byte(5);
    for (int i = 0; i < 3; i++) read_byte(1);
    check("fifo_drained", 32'(rx_ready), 0);
    check("fifo_drained_data", 32'(rx_data), 0);

    // Framing error
    send_frame(8'h77, 1'b0);
    repeat (4) @(negedge clk);
    check("frame_err_set", 32'(frame_err), 1);
    check("frame_err_no_push", 32'(rx_ready), 0);

    // Loopback of 0xC3
    loopback = 1'b1;
    repeat (2) @(negedge clk);
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    sb.push_back(8'hC3);
    k = 0;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("loop_tx_done", 32'(tx_ready), 1);
    read_byte(1);
    loopback = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid TX and mid RX frame
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    rxd_drv  = 1'b0;
    repeat (30) @(negedge clk);
    rst     = 1'b1;
    rxd_drv = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", 32'(uart_txd), 1);
    check("mid_rst_tx_ready", 32'(tx_ready), 1);
    check("mid_rst_rx_ready", 32'(rx_ready), 0);
    check("mid_rst_overrun", 32'(rx_overrun), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    sb.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    read_byte(1);
    check("post_rst_empty", 32'(rx_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
